// File: rtl/loop_seq_pkg.sv
// Shared types and default widths for the nested-loop address sequencer.
package loop_seq_pkg;

  localparam int unsigned CNT_W_DEF   = 10;
  localparam int unsigned ADDR_W_DEF  = 10;
  localparam int unsigned DELAY_W_DEF = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/seq_loop_cnt.sv
// Up-counter with clear, enable and terminal-count flag; wraps to 0 after limit.
module seq_loop_cnt #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc  = (cnt_q == limit);
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tc ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/loop_seq.sv
// Two-level loop sequencer: ITER periods of PER points, with start delay,
// per-point increment and end-of-period shift, feeding one memory port.
module loop_seq
  import loop_seq_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DELAY_W = DELAY_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               en,
  input  logic [ADDR_W-1:0]  cfg_start,
  input  logic [ADDR_W-1:0]  cfg_incr,
  input  logic [ADDR_W-1:0]  cfg_shift,
  input  logic [CNT_W-1:0]   cfg_per,
  input  logic [CNT_W-1:0]   cfg_iter,
  input  logic [DELAY_W-1:0] cfg_delay,
  output logic [ADDR_W-1:0]  addr,
  output logic               valid,
  output logic [CNT_W-1:0]   inner_cnt,
  output logic [CNT_W-1:0]   outer_cnt,
  output logic               busy,
  output logic               done
);

  state_e              state_q, state_d;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Shadow copy of the configuration, captured on the accepted run edge
  logic [ADDR_W-1:0]   start_q, incr_q, shift_q;
  logic [CNT_W-1:0]    per_q, iter_q;

  logic                load, cnt_clr, adv;
  logic                inner_tc, outer_tc;

  seq_loop_cnt #(.W(CNT_W)) u_inner (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (adv),
    .limit (per_q - 1'b1),
    .cnt   (inner_cnt),
    .tc    (inner_tc)
  );

  seq_loop_cnt #(.W(CNT_W)) u_outer (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (adv & inner_tc),
    .limit (iter_q - 1'b1),
    .cnt   (outer_cnt),
    .tc    (outer_tc)
  );

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    load    = 1'b0;
    cnt_clr = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (run) begin
          load = 1'b1;
          if (cfg_per != '0 && cfg_iter != '0) begin
            cnt_clr = 1'b1;
            if (cfg_delay == '0) begin
              state_d = S_RUN;
              addr_d  = cfg_start;
              valid_d = 1'b1;
            end else begin
              state_d = S_DELAY;
              delay_d = cfg_delay;
            end
          end
        end
      end
      S_DELAY: begin
        if (en) begin
          if (delay_q == DELAY_W'(1)) begin
            state_d = S_RUN;
            addr_d  = start_q;
            valid_d = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            delay_d = delay_q - 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!en) begin
          valid_d = 1'b0;
        end else if (inner_tc && outer_tc) begin
          // Final point consumed: address and counters keep their last values
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else begin
          adv     = 1'b1;
          valid_d = 1'b1;
          addr_d  = addr_q + incr_q + (inner_tc ? shift_q : '0);
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      delay_q <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b1;
      start_q <= '0;
      incr_q  <= '0;
      shift_q <= '0;
      per_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (load) begin
        start_q <= cfg_start;
        incr_q  <= cfg_incr;
        shift_q <= cfg_shift;
        per_q   <= cfg_per;
        iter_q  <= cfg_iter;
      end
    end
  end

  assign addr  = addr_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_loop_seq.sv
// Directed bench for loop_seq: expected points queued at run, checked as valid appears.
module tb_loop_seq;

  localparam int CNT_W = 10, ADDR_W = 10, DELAY_W = 5;

  logic               clk = 1'b0;
  logic               rst, run, en;
  logic [ADDR_W-1:0]  cfg_start, cfg_incr, cfg_shift;
  logic [CNT_W-1:0]   cfg_per, cfg_iter;
  logic [DELAY_W-1:0] cfg_delay;
  logic [ADDR_W-1:0]  addr;
  logic               valid, busy, done;
  logic [CNT_W-1:0]   inner_cnt, outer_cnt;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [CNT_W-1:0]  i;
    logic [CNT_W-1:0]  o;
  } pt_t;

  pt_t sb[$];
  int  checks = 0, errors = 0, nvalid = 0;

  always #5 clk = ~clk;

  loop_seq #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .DELAY_W(DELAY_W)) dut (
    .clk(clk), .rst(rst), .run(run), .en(en),
    .cfg_start(cfg_start), .cfg_incr(cfg_incr), .cfg_shift(cfg_shift),
    .cfg_per(cfg_per), .cfg_iter(cfg_iter), .cfg_delay(cfg_delay),
    .addr(addr), .valid(valid), .inner_cnt(inner_cnt), .outer_cnt(outer_cnt),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the nested walk
  task automatic push_exp(input logic [ADDR_W-1:0] st, input logic [ADDR_W-1:0] inc,
                          input logic [ADDR_W-1:0] sh, input int per, input int iter);
    logic [ADDR_W-1:0] a;
    pt_t p;
    a = st;
    for (int o = 0; o < iter; o++)
      for (int i = 0; i < per; i++) begin
        p.a = a; p.i = CNT_W'(i); p.o = CNT_W'(o);
        sb.push_back(p);
        a = a + inc + ((i == per - 1) ? sh : '0);
      end
  endtask

  task automatic pulse_run(input logic [ADDR_W-1:0] st, input logic [ADDR_W-1:0] inc,
                           input logic [ADDR_W-1:0] sh, input int per, input int iter,
                           input int dly);
    cfg_start = st; cfg_incr = inc; cfg_shift = sh;
    cfg_per = CNT_W'(per); cfg_iter = CNT_W'(iter); cfg_delay = DELAY_W'(dly);
    nvalid = 0;
    if (per != 0 && iter != 0) push_exp(st, inc, sh, per, iter);
    run = 1'b1;
    tick();
    run = 1'b0;
    // Scramble live config to prove the shadow copy is used
    cfg_start = 10'h155; cfg_incr = 10'h007; cfg_shift = 10'h033;
    cfg_per = 10'd9; cfg_iter = 10'd9; cfg_delay = 5'd3;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    chk("done_timeout", {31'b0, done}, 32'd1);
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      nvalid++;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        pt_t p;
        p = sb.pop_front();
        chk("addr", 32'(addr), 32'(p.a));
        chk("inner_cnt", 32'(inner_cnt), 32'(p.i));
        chk("outer_cnt", 32'(outer_cnt), 32'(p.o));
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; run = 1'b0; en = 1'b1;
    cfg_start = '0; cfg_incr = '0; cfg_shift = '0;
    cfg_per = '0; cfg_iter = '0; cfg_delay = '0;
    repeat (3) tick();
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd1);
    chk("rst_inner", 32'(inner_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Basic 3x2 walk, zero delay
    pulse_run(10'h010, 10'h001, 10'h002, 3, 2, 0);
    chk("t1_first_valid", {31'b0, valid}, 32'd1);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    chk("t1_done", {31'b0, done}, 32'd0);
    repeat (5) tick();
    chk("t1_last_valid", {31'b0, valid}, 32'd1);
    tick();
    chk("t1_done_after", {31'b0, done}, 32'd1);
    chk("t1_valid_after", {31'b0, valid}, 32'd0);
    chk("t1_addr_hold", 32'(addr), 32'h17);
    chk("t1_count", nvalid, 32'd6);
    chk("t1_sb_empty", sb.size(), 32'd0);
    tick();

    // Same walk with a 4-cycle start delay
    pulse_run(10'h010, 10'h001, 10'h002, 3, 2, 4);
    n = 0;
    while (valid !== 1'b1 && n < 50) begin
      chk("t2_delay_busy", {31'b0, busy}, 32'd1);
      chk("t2_delay_done", {31'b0, done}, 32'd0);
      tick();
      n++;
    end
    chk("t2_latency", n, 32'd4);
    wait_done();
    chk("t2_count", nvalid, 32'd6);
    tick();

    // Negative increment wraps below zero
    pulse_run(10'h002, 10'h3FF, 10'h000, 4, 1, 0);
    wait_done();
    chk("t3_count", nvalid, 32'd4);
    chk("t3_addr_final", 32'(addr), 32'h3FF);
    tick();

    // Zero per / zero iter are no-ops
    pulse_run(10'h020, 10'h001, 10'h000, 0, 3, 0);
    chk("t4a_done", {31'b0, done}, 32'd1);
    chk("t4a_busy", {31'b0, busy}, 32'd0);
    tick();
    pulse_run(10'h020, 10'h001, 10'h000, 3, 0, 2);
    chk("t4b_done", {31'b0, done}, 32'd1);
    chk("t4b_busy", {31'b0, busy}, 32'd0);
    repeat (3) tick();
    chk("t4_no_valid", nvalid, 32'd0);

    // Enable stall after the 2nd point, plus a run while busy
    pulse_run(10'h010, 10'h001, 10'h002, 3, 2, 0);
    tick();
    en = 1'b0;
    tick();
    chk("t5_stall1_valid", {31'b0, valid}, 32'd0);
    chk("t5_stall_addr", 32'(addr), 32'h11);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("t5_stall2_valid", {31'b0, valid}, 32'd0);
    en = 1'b1;
    tick();
    chk("t5_resume_valid", {31'b0, valid}, 32'd1);
    chk("t5_resume_addr", 32'(addr), 32'h12);
    wait_done();
    chk("t5_count", nvalid, 32'd6);
    chk("t5_sb_empty", sb.size(), 32'd0);
    repeat (3) tick();
    chk("t5_busy_run_ignored", {31'b0, busy}, 32'd0);

    // Reset mid-run, then clean restart
    pulse_run(10'h040, 10'h004, 10'h000, 4, 3, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_addr", 32'(addr), 32'd0);
    chk("t6_rst_valid", {31'b0, valid}, 32'd0);
    chk("t6_rst_done", {31'b0, done}, 32'd1);
    chk("t6_rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    sb.delete();
    tick();
    pulse_run(10'h010, 10'h001, 10'h002, 3, 2, 0);
    wait_done();
    chk("t6_count", nvalid, 32'd6);
    chk("t6_sb_empty", sb.size(), 32'd0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
